// File: rtl/mw_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : mw_writeback
//  Description : M->W pipeline register and write-back data selection.
//                Latches the memory-stage result and produces the register
//                file write port (address, data, enable) one edge later.
//                Sub-word load extension is compiled in only when the macro
//                MW_SUBWORD_LOAD_EN is defined; otherwise every load is a
//                plain word load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mw_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] DMRD_M,
  input  logic [31:0] PC8_M,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  WDSel_M,
  input  logic [2:0]  LdType_M,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic        WE_W,
  output logic [31:0] PC8_W,
  output logic        Valid_W
);

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC8 = 2'b10;

  // Latched W-stage contents
  logic        valid_q;
  logic        regwrite_q;
  logic [4:0]  a3_q;
  logic [31:0] alu_q;
  logic [31:0] dmrd_q;
  logic [31:0] pc8_q;
  logic [1:0]  wdsel_q;
  logic [31:0] load_data;

`ifdef MW_SUBWORD_LOAD_EN
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  logic [2:0]  ldtype_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load type register; flush turns it back into a plain word load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ldtype_q <= 3'd0;
    end else if (flush) begin
      ldtype_q <= 3'd0;
    end else if (!stall) begin
      ldtype_q <= LdType_M;
    end
  end
`else
  // Without sub-word loads the load type has no effect on the result
  logic unused_ldtype;
  assign unused_ldtype = ^LdType_M;
`endif

  // Pipeline register: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      a3_q       <= 5'd0;
      alu_q      <= 32'd0;
      dmrd_q     <= 32'd0;
      pc8_q      <= 32'd0;
      wdsel_q    <= WDSEL_ALU;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      a3_q       <= 5'd0;
      alu_q      <= 32'd0;
      dmrd_q     <= 32'd0;
      pc8_q      <= 32'd0;
      wdsel_q    <= WDSEL_ALU;
    end else if (!stall) begin
      valid_q    <= 1'b1;
      regwrite_q <= RegWrite_M;
      a3_q       <= A3_M;
      alu_q      <= ALUOut_M;
      dmrd_q     <= DMRD_M;
      pc8_q      <= PC8_M;
      wdsel_q    <= WDSel_M;
    end
  end

  // Load extension: pick byte/halfword from the latched address, then extend
  always_comb begin
    load_data = dmrd_q;
`ifdef MW_SUBWORD_LOAD_EN
    case (alu_q[1:0])
      2'd0:    byte_sel = dmrd_q[7:0];
      2'd1:    byte_sel = dmrd_q[15:8];
      2'd2:    byte_sel = dmrd_q[23:16];
      default: byte_sel = dmrd_q[31:24];
    endcase
    // addr[0] is deliberately ignored for halfword accesses
    half_sel = alu_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
    case (ldtype_q)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'd0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'd0, half_sel};
      default: load_data = dmrd_q;
    endcase
`endif
  end

  // Write-data mux, purely from latched state
  always_comb begin
    case (wdsel_q)
      WDSEL_ALU: WD_W = alu_q;
      WDSEL_MEM: WD_W = load_data;
      WDSEL_PC8: WD_W = pc8_q;
      default:   WD_W = 32'd0;
    endcase
  end

  // $0 is hard-wired, so a write to it is never issued
  assign WE_W    = regwrite_q & valid_q & (a3_q != 5'd0);
  assign A3_W    = a3_q;
  assign PC8_W   = pc8_q;
  assign Valid_W = valid_q;

endmodule
`default_nettype wire
